im_log_seq: RTL



---
 rtl/im_log_seq.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/im_log_seq.sv
// im_log_seq: sequential floor(log2(x)) with FRAC fractional bits.
// The integer part comes from a thermometer-stretch priority encode. The fraction
// is produced one bit per cycle by repeated squaring of the normalised mantissa.
// Optional build macro IM_LOG_ROUND_EN adds a guard iteration and rounds half-up
// into {log_int, log_frac}.
module im_log_seq #(
  parameter int unsigned W      = 18,
  parameter int unsigned FRAC   = 4,
  localparam int unsigned LOG_IW = $clog2(W + 1),
  localparam int unsigned FW     = (FRAC > 0) ? FRAC : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      number,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LOG_IW-1:0] log_int,
  output logic [FW-1:0]     log_frac,
  output logic              zero
);

`ifdef IM_LOG_ROUND_EN
  localparam int unsigned NITER = FRAC + 1;
`else
  localparam int unsigned NITER = FRAC;
`endif
  localparam int unsigned AW       = (NITER > 0) ? NITER : 1;
  localparam int unsigned CW       = (NITER > 1) ? $clog2(NITER) : 1;
  localparam int unsigned CNT_INIT = (NITER > 0) ? NITER - 1 : 0;
  localparam int unsigned RW       = LOG_IW + FW;

  typedef enum logic [1:0] {StIdle, StNorm, StFrac, StDone} state_e;

  state_e              state_q, state_d;
  logic [W-1:0]        num_q, num_d;
  logic [W-1:0]        m_q, m_d;
  logic [AW-1:0]       acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [LOG_IW-1:0]   int_q, int_d;
  logic                zflag_q, zflag_d;
  logic                out_valid_q, out_valid_d;
  logic [LOG_IW-1:0]   log_int_q, log_int_d;
  logic [FW-1:0]       log_frac_q, log_frac_d;
  logic                zero_q, zero_d;

  logic [W-1:0]        therm;
  logic [LOG_IW-1:0]   ones;
  logic [LOG_IW-1:0]   msb;
  logic [LOG_IW-1:0]   shamt;
  logic [W:0]          p_hi;
  logic                sq_bit;
  logic [W-1:0]        m_next;
  logic [RW-1:0]       res;

  // Thermometer stretch of the latched operand; popcount - 1 is the MSB index.
  always_comb begin
    therm      = '0;
    therm[W-1] = num_q[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      therm[i] = therm[i+1] | num_q[i];
    end
    ones = '0;
    for (int i = 0; i < W; i++) begin
      ones = ones + LOG_IW'(therm[i]);
    end
    msb   = ones - LOG_IW'(1);
    shamt = LOG_IW'(W - 1) - msb;
  end

  // Square the Q1.(W-1) mantissa; keep only bits [2W-1:W-1] of the product.
  assign p_hi   = (W + 1)'(({{W{1'b0}}, m_q} * {{W{1'b0}}, m_q}) >> (W - 1));
  assign sq_bit = p_hi[W];
  assign m_next = sq_bit ? p_hi[W:1] : p_hi[W-1:0];

  // Assemble {log_int, log_frac} from the working registers.
`ifdef IM_LOG_ROUND_EN
  logic [LOG_IW+AW-1:0] full;
  always_comb begin
    // Drop the guard bit and add it back as a half-up rounding increment.
    full = ({int_q, acc_q} >> 1) + (LOG_IW + AW)'(acc_q[0]);
    res  = (FRAC > 0) ? RW'(full) : RW'(full << 1);
    if (zflag_q) res = '0;
  end
`else
  always_comb begin
    res = RW'({int_q, acc_q});
    if (zflag_q) res = '0;
  end
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    m_d         = m_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    int_d       = int_q;
    zflag_d     = zflag_q;
    out_valid_d = out_valid_q;
    log_int_d   = log_int_q;
    log_frac_d  = log_frac_q;
    zero_d      = zero_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          num_d   = number;
          state_d = StNorm;
        end
      end
      StNorm: begin
        acc_d = '0;
        cnt_d = CW'(CNT_INIT);
        if (num_q == '0) begin
          zflag_d = 1'b1;
          int_d   = '0;
          m_d     = '0;
          state_d = StDone;
        end else begin
          zflag_d = 1'b0;
          int_d   = msb;
          m_d     = num_q << shamt;
          state_d = (NITER > 0) ? StFrac : StDone;
        end
      end
      StFrac: begin
        m_d   = m_next;
        acc_d = (acc_q << 1) | AW'(sq_bit);
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StDone: begin
        // First DONE cycle publishes the result; it then holds until accepted.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          log_int_d   = res[RW-1:FW];
          log_frac_d  = res[FW-1:0];
          zero_d      = zflag_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      num_q       <= '0;
      m_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      int_q       <= '0;
      zflag_q     <= 1'b0;
      out_valid_q <= 1'b0;
      log_int_q   <= '0;
      log_frac_q  <= '0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      m_q         <= m_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      int_q       <= int_d;
      zflag_q     <= zflag_d;
      out_valid_q <= out_valid_d;
      log_int_q   <= log_int_d;
      log_frac_q  <= log_frac_d;
      zero_q      <= zero_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign log_int   = log_int_q;
  assign log_frac  = log_frac_q;
  assign zero      = zero_q;

endmodule
